// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin front end for a single-port RAM
// with synchronous read. One transaction at a time, four cycles each:
// IDLE (arbitrate + latch) -> ISSUE (RAM strobe) -> WAIT (read data returns)
// -> DONE (ack pulse).
//
// Ports
//   clk, rst                    clock, async active-high reset
//   req0/1, we0/1               request and write/read select per requester
//   addr0/1, wdata0/1           address / write data per requester
//   ack0, ack1                  one-cycle completion pulse per requester
//   rdata                       shared read data, valid with ackN on a read
//   ram_en, ram_we              RAM strobe / write enable
//   ram_addr, ram_din           RAM address / write data
//   ram_dout                    RAM read data (one cycle after ram_en)
module ram_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // Transaction captured at the IDLE edge; requester inputs are ignored
  // afterwards so late changes cannot disturb the access in flight.
  typedef struct packed {
    logic          win;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  state_t          state, state_nxt;
  txn_t            cur;
  logic            last;     // requester served most recently
  logic            grant;    // combinational winner while in IDLE
  logic            start;
  logic [DW-1:0]   rdata_q;

  // On a tie the requester that was not served last wins; otherwise the
  // only requester wins.
  assign grant = (req0 && req1) ? ~last : req1;
  assign start = (state == IDLE) && (req0 || req1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 || req1) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction latch, round-robin pointer and read-data register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur     <= '0;
      last    <= 1'b1;
      rdata_q <= '0;
    end else begin
      if (start) begin
        cur.win  <= grant;
        cur.we   <= grant ? we1    : we0;
        cur.addr <= grant ? addr1  : addr0;
        cur.data <= grant ? wdata1 : wdata0;
        last     <= grant;
      end
      // RAM returns data the cycle after the ISSUE strobe; writes keep rdata.
      if (state == WAIT && !cur.we) rdata_q <= ram_dout;
    end
  end

  // Outputs decoded from state so reset drops strobes without a clock edge
  always_comb begin
    ram_en = 1'b0;
    ram_we = 1'b0;
    ack0   = 1'b0;
    ack1   = 1'b0;
    case (state)
      ISSUE: begin
        ram_en = 1'b1;
        ram_we = cur.we;
      end
      DONE: begin
        ack0 = ~cur.win;
        ack1 =  cur.win;
      end
      default: ;
    endcase
  end

  assign ram_addr = cur.addr;
  assign ram_din  = cur.data;
  assign rdata    = rdata_q;

endmodule
